mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Data-memory access stage between the EX/MEM pipeline registers and the load
//  sign/zero extender. Turns CPU load/store requests into word-aligned memory
//  transactions with byte enables over a req/ack handshake, stalling the core
//  until completion. Returns load data lane-shifted so the addressed byte/half
//  sits at bits [7:0]/[15:0]; the downstream extender then sign/zero-extends.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles mem_req stays high without mem_ack before bus error
// PORTS
//  clk        in   1   single system clock, rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  req        in   1   CPU access request; held high by core until done
//  we         in   1   1 = store, 0 = load; sampled at accept
//  size       in   2   00 byte, 01 half, 10 word, 11 reserved; sampled at accept
//  addr       in   32  byte address; sampled at accept
//  wdata      in   32  store data, low-aligned; sampled at accept
//  stall      out  1   freeze pipeline; = req & ~done (combinational)
//  done       out  1   one-cycle completion pulse (registered)
//  err        out  1   valid with done: misaligned/reserved size or timeout
//  rdata      out  32  lane-shifted load data, valid with done, held until next done
//  mem_req    out  1   memory request, registered
//  mem_we     out  1   memory write strobe, valid with mem_req
//  mem_addr   out  32  {addr[31:2],2'b00}
//  mem_be     out  4   byte enables, bit i = bits [8i+7:8i]
//  mem_wdata  out  32  lane-replicated store data
//  mem_rdata  in   32  memory read data, valid in mem_ack cycle
//  mem_ack    in   1   memory completion, one cycle
// BEHAVIOUR
//  Reset: state IDLE; done, err, mem_req, mem_we = 0; rdata, mem_addr, mem_be,
//   mem_wdata, timeout counter = 0. Reset mid-transaction aborts to IDLE, no done.
//  States IDLE -> WAIT -> RESP -> IDLE; IDLE -> RESP directly on alignment error.
//  IDLE: req=1 accepts (cycle T); latch we/size/addr/wdata. Aligned -> WAIT,
//   mem_req=1 from T+1. Misaligned (half & addr[0]; word & addr[1:0]!=0;
//   size=11) -> RESP, no mem_req ever driven.
//  WAIT: mem_req held; counter increments each cycle. mem_ack -> drop mem_req,
//   capture rdata (loads only), -> RESP. Counter reaching TIMEOUT_CYCLES-1 with
//   no ack -> drop mem_req, err, -> RESP. Ack in same cycle as timeout: ack wins.
//  RESP: done=1 (and err if set) for exactly one cycle, -> IDLE. A new req is
//   accepted no earlier than the cycle after done (no same-cycle re-accept).
//  Latency: ack at T+k -> done at T+k+1; zero-wait ack at T+1 -> done T+2.
//   Misaligned -> done+err at T+1.
//  Enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
//  Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
//  Load data: byte mem_rdata>>(8*addr[1:0]); half mem_rdata>>(16*addr[1]);
//   word as-is; upper bits zero-filled (extension is downstream).
//  Stores: rdata unchanged. mem_ack outside WAIT ignored. Loads return all 32
//   lane bits read; mem_be still reflects size for loads.
// STRUCTURE
//  Shared package: size codes (SZ_BYTE/SZ_HALF/SZ_WORD), state encoding,
//   TIMEOUT_CYCLES default.
//  Sub-module lane_align: combinational be/wdata replication and rdata shifting
//   from size + addr[1:0] (reused by any future I/O port).
// TESTING
//  1 Load byte addr 0x1003, mem_rdata 0xAABBCCDD, ack at T+2 -> mem_addr 0x1000,
//    mem_be 1000, done at T+3, rdata 0x000000AA, err 0.
//  2 Store half addr 0x2002, wdata 0x00001234 -> mem_we 1, mem_be 1100,
//    mem_wdata 0x12341234, mem_addr 0x2000; zero-wait ack -> done T+2.
//  3 Load word addr 0x3001 -> no mem_req, done+err at T+1; size 11 same.
//  4 No ack -> mem_req high exactly 16 cycles, then done+err; ack in 16th cycle
//    -> err 0, normal done.
//  5 rst_n low during WAIT -> mem_req, done fall immediately, no done pulse;
//    next req after release completes normally.
//  6 Back-to-back loads, req held -> second accepted cycle after first done;
//    stall low only in done cycles; spurious mem_ack in IDLE ignored.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access stage.
// Provides:
//   size codes   SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD
//   state_t      access-stage FSM encoding
//   DEF_TIMEOUT_CYCLES  default bus timeout
//   is_misaligned()     alignment/size legality check
package mem_access_unit_pkg;

    localparam int DEF_TIMEOUT_CYCLES = 16;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Reserved size is reported as an alignment error so it never reaches the bus.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-aligned memory bus between the access stage (master) and memory (slave).
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata : master -> slave
//   mem_rdata/mem_ack                        : slave -> master, valid in ack cycle
interface mem_access_unit_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Combinational byte-lane steering for a 32-bit little-endian bus.
//   size, addr_lo  in  access size code and byte offset within the word
//   wdata          in  low-aligned store data
//   rdata_raw      in  word read from memory
//   be             out byte enables (bit i = bits [8i+7:8i])
//   wdata_rep      out store data replicated across lanes
//   rdata_shift    out read data shifted so the addressed byte/half is at bit 0
module mem_access_unit_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_shift
);

    // Upper bits fill with zeros from the shift; sign/zero extension is downstream.
    always_comb begin
        be          = 4'b0000;
        wdata_rep   = wdata;
        rdata_shift = rdata_raw;
        case (size)
            SZ_BYTE: begin
                be          = 4'b0001 << addr_lo;
                wdata_rep   = {4{wdata[7:0]}};
                rdata_shift = rdata_raw >> {addr_lo, 3'b000};
            end
            SZ_HALF: begin
                be          = 4'b0011 << addr_lo;
                wdata_rep   = {2{wdata[15:0]}};
                rdata_shift = rdata_raw >> {addr_lo[1], 4'b0000};
            end
            SZ_WORD: begin
                be = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: turns CPU load/store requests into word-aligned
// bus transactions, stalls the core until completion, returns lane-shifted data.
//   clk, rst_n         clock, async active-low reset
//   req/we/size/addr/wdata   CPU request (fields sampled at accept)
//   stall              req & ~done
//   done/err/rdata     one-cycle completion pulse, error flag, load data
//   mbus               memory bus (master side)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no access in flight; accept on req
// ST_WAIT | mem_req asserted, waiting for mem_ack or timeout
// ST_RESP | done (and err) pulsed this cycle; back to IDLE next
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    mem_access_unit_if.master mbus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t            state, state_nxt;
    logic              accept, misal, ack_hit, tmo;
    logic              we_q;
    logic [1:0]        size_q, alo_q;
    logic [CNT_W-1:0]  cnt;
    logic              mem_req_q, mem_we_q;
    logic [31:0]       mem_addr_q, mem_wdata_q;
    logic [3:0]        mem_be_q;
    logic [1:0]        la_size, la_alo;
    logic [3:0]        la_be;
    logic [31:0]       la_wdata, la_rdata;

    // Live request fields steer the lanes at accept; latched ones at ack time.
    assign la_size = (state == ST_IDLE) ? size      : size_q;
    assign la_alo  = (state == ST_IDLE) ? addr[1:0] : alo_q;

    mem_access_unit_lane_align u_lane_align (
        .size        (la_size),
        .addr_lo     (la_alo),
        .wdata       (wdata),
        .rdata_raw   (mbus.mem_rdata),
        .be          (la_be),
        .wdata_rep   (la_wdata),
        .rdata_shift (la_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Ack is tested before the timeout so an ack in the last cycle wins.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ack_hit   = 1'b0;
        tmo       = 1'b0;
        misal     = is_misaligned(size, addr[1:0]);
        case (state)
            ST_IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = misal ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mbus.mem_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = ST_RESP;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo       = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done        <= 1'b0;
            err         <= 1'b0;
            rdata       <= '0;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            alo_q       <= 2'b00;
            cnt         <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            done <= (accept & misal) | ack_hit | tmo;
            err  <= (accept & misal) | tmo;
            if (accept) begin
                we_q   <= we;
                size_q <= size;
                alo_q  <= addr[1:0];
                cnt    <= '0;
                if (!misal) begin
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= we;
                    mem_addr_q  <= {addr[31:2], 2'b00};
                    mem_be_q    <= la_be;
                    mem_wdata_q <= la_wdata;
                end
            end
            if (state == ST_WAIT && !ack_hit && !tmo) begin
                cnt <= cnt + 1'b1;
            end
            if (ack_hit || tmo) begin
                mem_req_q <= 1'b0;
                mem_we_q  <= 1'b0;
            end
            if (ack_hit && !we_q) begin
                rdata <= la_rdata;
            end
        end
    end

    assign stall          = req & ~done;
    assign mbus.mem_req   = mem_req_q;
    assign mbus.mem_we    = mem_we_q;
    assign mbus.mem_addr  = mem_addr_q;
    assign mbus.mem_be    = mem_be_q;
    assign mbus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall, done, err;
    logic [31:0] rdata;

    mem_access_unit_if mbus();

    mem_access_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .we    (we),
        .size  (size),
        .addr  (addr),
        .wdata (wdata),
        .stall (stall),
        .done  (done),
        .err   (err),
        .rdata (rdata),
        .mbus  (mbus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          done_cyc;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] word;
    } bus_t;

    resp_t       sb_q[$];
    bus_t        plan_q[$];
    logic [31:0] model_rdata = '0;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte-level view of the access. Bytes addr_lo..addr_lo+n-1
    // are touched; store bytes repeat across lanes; a load returns the bytes
    // from the addressed one upward, zeros above the top of the word.
    task automatic launch(input logic w, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] wd, input int d, input logic [31:0] wrd);
        int    n, lo;
        bit    mis, acked;
        bus_t  b;
        resp_t r;
        n     = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
        lo    = int'(a[1:0]);
        mis   = (s == 2'b11) || (lo % n != 0);
        acked = !mis && (d < TMO);
        if (!mis) begin
            b.we    = w;
            b.addr  = {a[31:2], 2'b00};
            b.delay = d;
            b.word  = wrd;
            for (int i = 0; i < 4; i++) begin
                b.be[i]            = (i >= lo) && (i < lo + n);
                b.wdata[8*i +: 8]  = wd[8*(i % n) +: 8];
            end
            plan_q.push_back(b);
        end
        if (acked && !w) begin
            model_rdata = '0;
            for (int i = 0; i < 4; i++)
                if (lo + i < 4) model_rdata[8*i +: 8] = wrd[8*(lo+i) +: 8];
        end
        r.err      = mis || !acked;
        r.rdata    = model_rdata;
        r.done_cyc = cyc + (mis ? 1 : ((d >= TMO) ? TMO - 1 : d) + 2);
        sb_q.push_back(r);
        req   = 1'b1;
        we    = w;
        size  = s;
        addr  = a;
        wdata = wd;
    endtask

    task automatic run(input logic w, input logic [1:0] s, input logic [31:0] a,
                       input logic [31:0] wd, input int d, input logic [31:0] wrd, input bit keep);
        bit seen;
        int dcyc;
        @(negedge clk);
        launch(w, s, a, wd, d, wrd);
        dcyc = sb_q[sb_q.size()-1].done_cyc;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            check("stall", 32'(stall), 32'(cyc != dcyc));
            if (done) seen = 1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_wait: actual=no_done expected=done within 40 cycles");
        end
        if (!keep) req = 1'b0;
    endtask

    // Scoreboard monitor.
    resp_t mr;
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: actual=done expected=none (cycle %0d)", cyc);
            end else begin
                mr = sb_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(mr.done_cyc));
                check("err", 32'(err), 32'(mr.err));
                check("rdata", rdata, mr.rdata);
            end
        end
    end

    // Memory responder: follows the per-transaction plan, checks bus fields,
    // counts mem_req cycles, and throws spurious acks while the bus is idle.
    initial begin
        bus_t b;
        int   n;
        bit   active;
        n = 0;
        active = 0;
        b.delay = 0;
        b.word = '0;
        mbus.mem_ack = 1'b0;
        mbus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            mbus.mem_ack   = 1'b0;
            mbus.mem_rdata = $urandom;
            if (!rst_n) begin
                active = 0;
                continue;
            end
            if (mbus.mem_req) begin
                if (!active) begin
                    active = 1;
                    n = 0;
                    if (plan_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unplanned_mem_req: actual=mem_req expected=none (cycle %0d)", cyc);
                        b.delay = 0;
                        b.word = '0;
                        b.we = 1'b0;
                    end else begin
                        b = plan_q.pop_front();
                        check("mem_addr", mbus.mem_addr, b.addr);
                        check("mem_be", 32'(mbus.mem_be), 32'(b.be));
                        check("mem_we", 32'(mbus.mem_we), 32'(b.we));
                        if (b.we) check("mem_wdata", mbus.mem_wdata, b.wdata);
                    end
                end
                if (n == b.delay) begin
                    mbus.mem_ack   = 1'b1;
                    mbus.mem_rdata = b.word;
                end
                n++;
            end else begin
                if (active) begin
                    active = 0;
                    check("mem_req_cycles", 32'(n), 32'((b.delay < TMO) ? b.delay + 1 : TMO));
                end else if ($urandom_range(3) == 0) begin
                    mbus.mem_ack = 1'b1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  s;
        logic [31:0] a;
        int          d;

        repeat (3) @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_req", 32'(mbus.mem_req), 32'd0);
        check("rst_mem_we", 32'(mbus.mem_we), 32'd0);
        check("rst_mem_addr", mbus.mem_addr, 32'd0);
        check("rst_mem_be", 32'(mbus.mem_be), 32'd0);
        check("rst_mem_wdata", mbus.mem_wdata, 32'd0);
        rst_n = 1'b1;

        run(1'b0, 2'b00, 32'h0000_1003, 32'h0, 1, 32'hAABB_CCDD, 0);
        run(1'b1, 2'b01, 32'h0000_2002, 32'h0000_1234, 0, $urandom, 0);
        run(1'b0, 2'b10, 32'h0000_3001, 32'h0, 0, $urandom, 0);
        run(1'b0, 2'b11, 32'h0000_4000, 32'h0, 0, $urandom, 0);
        run(1'b0, 2'b10, 32'h0000_5000, 32'h0, 20, 32'h1111_2222, 0);
        run(1'b0, 2'b10, 32'h0000_6000, 32'h0, 15, 32'hCAFE_F00D, 0);
        run(1'b0, 2'b01, 32'h0000_7002, 32'h0, 3, 32'h8765_4321, 1);
        run(1'b0, 2'b00, 32'h0000_7001, 32'h0, 0, 32'h0102_0304, 1);
        run(1'b1, 2'b00, 32'h0000_7003, 32'h0000_00A5, 2, $urandom, 0);

        // Reset in the middle of a wait: bus drops at once, no done follows.
        @(negedge clk);
        launch(1'b0, 2'b10, 32'h0000_8000, 32'h0, 30, $urandom);
        repeat (4) @(negedge clk);
        check("pre_rst_mem_req", 32'(mbus.mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_mem_req", 32'(mbus.mem_req), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_rdata", rdata, 32'd0);
        sb_q.delete();
        plan_q.delete();
        model_rdata = '0;
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run(1'b0, 2'b10, 32'h0000_9000, 32'h0, 1, 32'h5A5A_A5A5, 0);

        for (int t = 0; t < 200; t++) begin
            s = 2'($urandom_range(3));
            a = $urandom;
            if ($urandom_range(4) != 0) begin
                if (s == 2'b01) a[0] = 1'b0;
                if (s == 2'b10) a[1:0] = 2'b00;
            end
            d = ($urandom_range(9) == 0) ? $urandom_range(18, 14) : $urandom_range(4, 0);
            run(1'($urandom_range(1)), s, a, $urandom, d, $urandom, 1'($urandom_range(1)));
            if (!req && $urandom_range(1) == 1) repeat ($urandom_range(2)) @(negedge clk);
        end

        req = 1'b0;
        repeat (6) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("plan_drained", 32'(plan_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
